// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a small data-memory request FSM.
// Holds EX results for the MEM stage and stalls upstream while a dcache access is outstanding.
module ex_mem_reg (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        enable,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] instr_EX,
    input  logic [31:0] npc_EX,
    input  logic [31:0] aluout_EX,
    input  logic [31:0] storedata_EX,
    input  logic        RegWr_EX,
    input  logic        memWr_EX,
    input  logic        memtoReg_EX,
    input  logic        halt_EX,
    output logic [31:0] instr_MEM,
    output logic [31:0] npc_MEM,
    output logic [31:0] aluout_MEM,
    output logic [31:0] storedata_MEM,
    output logic        RegWr_MEM,
    output logic        memWr_MEM,
    output logic        memtoReg_MEM,
    output logic        halt_MEM,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic        mem_busy
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] storedata_q, storedata_d;
    logic        regwr_q, regwr_d;
    logic        memwr_q, memwr_d;
    logic        memtoreg_q, memtoreg_d;
    logic        halt_q, halt_d;
    logic        busy;
    logic        advance;

    assign busy    = (state_q == REQ);
    assign advance = (enable | flush) & ~busy & ~halt_q;

    // Flush beats enable; an outstanding request or a halted stage blocks both.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        npc_d       = npc_q;
        aluout_d    = aluout_q;
        storedata_d = storedata_q;
        regwr_d     = regwr_q;
        memwr_d     = memwr_q;
        memtoreg_d  = memtoreg_q;
        halt_d      = halt_q;

        if (advance) begin
            if (flush) begin
                state_d     = IDLE;
                instr_d     = '0;
                npc_d       = '0;
                aluout_d    = '0;
                storedata_d = '0;
                regwr_d     = 1'b0;
                memwr_d     = 1'b0;
                memtoreg_d  = 1'b0;
                halt_d      = 1'b0;
            end else begin
                state_d     = (memtoReg_EX | memWr_EX) ? REQ : IDLE;
                instr_d     = instr_EX;
                npc_d       = npc_EX;
                aluout_d    = aluout_EX;
                storedata_d = storedata_EX;
                regwr_d     = RegWr_EX;
                memwr_d     = memWr_EX;
                memtoreg_d  = memtoReg_EX;
                halt_d      = halt_EX;
            end
        end else if ((state_q == REQ) && dhit) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            npc_q       <= '0;
            aluout_q    <= '0;
            storedata_q <= '0;
            regwr_q     <= 1'b0;
            memwr_q     <= 1'b0;
            memtoreg_q  <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            npc_q       <= npc_d;
            aluout_q    <= aluout_d;
            storedata_q <= storedata_d;
            regwr_q     <= regwr_d;
            memwr_q     <= memwr_d;
            memtoreg_q  <= memtoreg_d;
            halt_q      <= halt_d;
        end
    end

    // A store-conditional carries both memWr and memtoReg but only issues the write.
    assign dREN          = busy & memtoreg_q & ~memwr_q;
    assign dWEN          = busy & memwr_q;
    assign mem_busy      = busy;
    assign instr_MEM     = instr_q;
    assign npc_MEM       = npc_q;
    assign aluout_MEM    = aluout_q;
    assign storedata_MEM = storedata_q;
    assign RegWr_MEM     = regwr_q;
    assign memWr_MEM     = memwr_q;
    assign memtoReg_MEM  = memtoreg_q;
    assign halt_MEM      = halt_q;
    assign daddr         = aluout_q;
    assign dstore        = storedata_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: a vector table walked edge by edge, then
// hand-written halt, bounded-wait load and reset-during-request sequences.
module tb_ex_mem_reg;

    logic        CLK;
    logic        nRST, enable, flush, dhit;
    logic [31:0] instr_EX, npc_EX, aluout_EX, storedata_EX;
    logic        RegWr_EX, memWr_EX, memtoReg_EX, halt_EX;
    logic [31:0] instr_MEM, npc_MEM, aluout_MEM, storedata_MEM;
    logic        RegWr_MEM, memWr_MEM, memtoReg_MEM, halt_MEM;
    logic        dREN, dWEN, mem_busy;
    logic [31:0] daddr, dstore;

    int n_cmp  = 0;
    int n_fail = 0;

    ex_mem_reg dut (
        .CLK(CLK), .nRST(nRST), .enable(enable), .flush(flush), .dhit(dhit),
        .instr_EX(instr_EX), .npc_EX(npc_EX), .aluout_EX(aluout_EX), .storedata_EX(storedata_EX),
        .RegWr_EX(RegWr_EX), .memWr_EX(memWr_EX), .memtoReg_EX(memtoReg_EX), .halt_EX(halt_EX),
        .instr_MEM(instr_MEM), .npc_MEM(npc_MEM), .aluout_MEM(aluout_MEM), .storedata_MEM(storedata_MEM),
        .RegWr_MEM(RegWr_MEM), .memWr_MEM(memWr_MEM), .memtoReg_MEM(memtoReg_MEM), .halt_MEM(halt_MEM),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .mem_busy(mem_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ctl = {RegWr, memWr, memtoReg, halt}; mem = {dREN, dWEN, mem_busy}
    typedef struct {
        logic        rst_n, en, fl, dh;
        logic [31:0] instr, npc, alu, sd;
        logic [3:0]  ctl;
        logic [31:0] e_instr, e_npc, e_alu, e_sd;
        logic [3:0]  e_ctl;
        logic [2:0]  e_mem;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] LW_I  = 32'h8C880004, LW_N  = 32'h00000404, LW_A  = 32'h00000100, LW_S  = 32'h0000DEAD;
    localparam logic [31:0] SW_I  = 32'hAC890008, SW_N  = 32'h00000408, SW_A  = 32'h00000200, SW_S  = 32'hCAFEBABE;
    localparam logic [31:0] ADD_I = 32'h01095020, ADD_N = 32'h0000040C, ADD_A = 32'h00000015, ADD_S = 32'h00000007;
    localparam logic [31:0] SC_I  = 32'hE0880000, SC_N  = 32'h00000410, SC_A  = 32'h00000300, SC_S  = 32'h00000001;
    localparam logic [31:0] Z     = 32'h0;

    function automatic vec_t mk(input logic r, input logic e, input logic f, input logic d,
                                input logic [31:0] i, input logic [31:0] n, input logic [31:0] a,
                                input logic [31:0] s, input logic [3:0] c,
                                input logic [31:0] ei, input logic [31:0] en_, input logic [31:0] ea,
                                input logic [31:0] es, input logic [3:0] ec, input logic [2:0] em);
        vec_t v;
        v.rst_n = r; v.en = e; v.fl = f; v.dh = d;
        v.instr = i; v.npc = n; v.alu = a; v.sd = s; v.ctl = c;
        v.e_instr = ei; v.e_npc = en_; v.e_alu = ea; v.e_sd = es; v.e_ctl = ec; v.e_mem = em;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL step%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        nRST = v.rst_n; enable = v.en; flush = v.fl; dhit = v.dh;
        instr_EX = v.instr; npc_EX = v.npc; aluout_EX = v.alu; storedata_EX = v.sd;
        {RegWr_EX, memWr_EX, memtoReg_EX, halt_EX} = v.ctl;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        chk("instr_MEM", idx, instr_MEM, v.e_instr);
        chk("npc_MEM", idx, npc_MEM, v.e_npc);
        chk("aluout_MEM", idx, aluout_MEM, v.e_alu);
        chk("storedata_MEM", idx, storedata_MEM, v.e_sd);
        chk("daddr", idx, daddr, v.e_alu);
        chk("dstore", idx, dstore, v.e_sd);
        chk("ctl", idx, {28'h0, RegWr_MEM, memWr_MEM, memtoReg_MEM, halt_MEM}, {28'h0, v.e_ctl});
        chk("dREN/dWEN/busy", idx, {29'h0, dREN, dWEN, mem_busy}, {29'h0, v.e_mem});
    endtask

    initial begin
        vec_t v;
        int   k;
        bit   seen;

        //           rst en fl dh  instr  npc    alu    sd     ctl      e_instr e_npc  e_alu  e_sd   e_ctl    e_mem
        vecs.push_back(mk(0, 1, 1, 1, LW_I,  LW_N,  LW_A,  LW_S,  4'b1010, Z,    Z,    Z,    Z,    4'b0000, 3'b000));
        vecs.push_back(mk(1, 1, 0, 0, LW_I,  LW_N,  LW_A,  LW_S,  4'b1010, LW_I, LW_N, LW_A, LW_S, 4'b1010, 3'b101));
        vecs.push_back(mk(1, 1, 0, 0, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, LW_I, LW_N, LW_A, LW_S, 4'b1010, 3'b101));
        vecs.push_back(mk(1, 0, 1, 0, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, LW_I, LW_N, LW_A, LW_S, 4'b1010, 3'b101));
        vecs.push_back(mk(1, 0, 0, 1, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, LW_I, LW_N, LW_A, LW_S, 4'b1010, 3'b000));
        vecs.push_back(mk(1, 0, 0, 1, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, LW_I, LW_N, LW_A, LW_S, 4'b1010, 3'b000));
        vecs.push_back(mk(1, 1, 0, 1, SW_I,  SW_N,  SW_A,  SW_S,  4'b0100, SW_I, SW_N, SW_A, SW_S, 4'b0100, 3'b011));
        vecs.push_back(mk(1, 0, 0, 1, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, SW_I, SW_N, SW_A, SW_S, 4'b0100, 3'b000));
        vecs.push_back(mk(1, 0, 1, 0, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, Z,    Z,    Z,    Z,    4'b0000, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, Z,    Z,    Z,    Z,    4'b0000, 3'b000));
        vecs.push_back(mk(1, 0, 0, 0, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, Z,    Z,    Z,    Z,    4'b0000, 3'b000));
        vecs.push_back(mk(1, 1, 0, 0, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, ADD_I, ADD_N, ADD_A, ADD_S, 4'b1000, 3'b000));
        vecs.push_back(mk(1, 1, 1, 0, SW_I,  SW_N,  SW_A,  SW_S,  4'b0100, Z,    Z,    Z,    Z,    4'b0000, 3'b000));
        vecs.push_back(mk(1, 1, 0, 0, SC_I,  SC_N,  SC_A,  SC_S,  4'b1110, SC_I, SC_N, SC_A, SC_S, 4'b1110, 3'b011));
        vecs.push_back(mk(0, 1, 1, 1, LW_I,  LW_N,  LW_A,  LW_S,  4'b1010, Z,    Z,    Z,    Z,    4'b0000, 3'b000));
        vecs.push_back(mk(1, 1, 0, 0, Z,     Z,     Z,     Z,     4'b1000, Z,    Z,    Z,    Z,    4'b1000, 3'b000));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Halt is sticky: enable, flush and new EX data are all ignored until reset.
        v = mk(1, 1, 0, 0, 32'hFC000000, 32'h500, 32'h0, 32'h0, 4'b0001,
               32'hFC000000, 32'h500, 32'h0, 32'h0, 4'b0001, 3'b000);
        applyStimulus(v);
        checkOutput(100, v);
        for (int i = 0; i < 3; i++) begin
            v = mk(1, 1, (i == 2), 0, LW_I, LW_N, LW_A, LW_S, 4'b1010,
                   32'hFC000000, 32'h500, 32'h0, 32'h0, 4'b0001, 3'b000);
            applyStimulus(v);
            checkOutput(101 + i, v);
        end
        v = mk(0, 1, 0, 0, LW_I, LW_N, LW_A, LW_S, 4'b1010, Z, Z, Z, Z, 4'b0000, 3'b000);
        applyStimulus(v);
        checkOutput(104, v);

        // Load whose dhit arrives late; wait for the stall to drop within a bounded window.
        v = mk(1, 1, 0, 0, LW_I, LW_N, LW_A, LW_S, 4'b1010, LW_I, LW_N, LW_A, LW_S, 4'b1010, 3'b101);
        applyStimulus(v);
        checkOutput(200, v);
        enable = 1'b0;
        @(posedge CLK); #1;
        dhit = 1'b1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 10) begin
            @(posedge CLK); #1;
            k++;
            if (!mem_busy) seen = 1'b1;
        end
        chk("busy_released_cycles", 201, k, 1);
        chk("dREN_after_dhit", 202, {31'h0, dREN}, 32'h0);
        dhit = 1'b0;

        // Reset in the middle of a request drops it with no completion.
        v = mk(1, 1, 0, 0, SW_I, SW_N, SW_A, SW_S, 4'b0100, SW_I, SW_N, SW_A, SW_S, 4'b0100, 3'b011);
        applyStimulus(v);
        checkOutput(300, v);
        v = mk(0, 0, 0, 0, SW_I, SW_N, SW_A, SW_S, 4'b0100, Z, Z, Z, Z, 4'b0000, 3'b000);
        applyStimulus(v);
        checkOutput(301, v);
        v = mk(1, 0, 0, 1, SW_I, SW_N, SW_A, SW_S, 4'b0100, Z, Z, Z, Z, 4'b0000, 3'b000);
        applyStimulus(v);
        checkOutput(302, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL provide: CLK  in  1  rising-edge clock; single clock domain.
REQ-002 SHALL provide: nRST  in  1  reset, synchronous, active-low.
REQ-003 SHALL provide: enable  in  1  pipeline advance (ihit-qualified), from hazard/control.
REQ-004 SHALL provide: flush  in  1  insert bubble in MEM stage.
REQ-005 SHALL provide: dhit  in  1  data-memory transaction complete.
REQ-006 SHALL provide: instr_EX, npc_EX, aluout_EX, storedata_EX  in  32 each  EX-stage instruction, PC+4, ALU result, forwarded store data.
REQ-007 SHALL provide: RegWr_EX, memWr_EX, memtoReg_EX, halt_EX  in  1 each  EX-stage controls.
REQ-008 SHALL provide: instr_MEM, npc_MEM, aluout_MEM, storedata_MEM  out  32 each  registered copies; instr_MEM feeds the forwarding unit.
REQ-009 SHALL provide: RegWr_MEM, memWr_MEM, memtoReg_MEM, halt_MEM  out  1 each  registered controls.
REQ-010 SHALL provide: dREN, dWEN  out  1 each  data-memory read/write request.
REQ-011 SHALL provide: daddr, dstore  out  32 each  equal to aluout_MEM and storedata_MEM.
REQ-012 SHALL provide: mem_busy  out  1  stall request to upstream stages; high while a request is outstanding.

Function
REQ-013 SHALL contain a request FSM with states IDLE, REQ, DONE.
REQ-014 advance = (enable | flush) & ~mem_busy & ~halt_MEM.
REQ-015 On advance with flush=1: all data/instr outputs 0, all controls 0, FSM to IDLE (bubble); flush beats enable.
REQ-016 On advance with flush=0, enable=1: all outputs load EX inputs on the edge; latency exactly 1 cycle.
REQ-017 On the loading edge, FSM goes to REQ if memtoReg_EX|memWr_EX, else IDLE.
REQ-018 If no advance occurs: every register holds its value.
REQ-019 In REQ: dREN = memtoReg_MEM & ~memWr_MEM; dWEN = memWr_MEM (SC, with both set, issues write only); mem_busy = 1.
REQ-020 In REQ with dhit=1: next state DONE; dREN/dWEN/mem_busy are low from the next cycle.
REQ-021 dhit SHALL be ignored in IDLE and DONE.
REQ-022 In IDLE and DONE: dREN=dWEN=0, mem_busy=0.
REQ-023 dhit in the same cycle REQ is entered SHALL complete the request (min request length 1 cycle).
REQ-024 flush or enable while mem_busy=1 SHALL be ignored; the outstanding request is never cancelled.
REQ-025 Once halt_MEM=1, the stage SHALL freeze (no advance) until reset; halt_MEM is sticky.
REQ-026 A new memory instruction loaded directly from DONE SHALL re-enter REQ (back-to-back accesses).
REQ-027 Register-to-register writes of zero-valued fields SHALL be passed unchanged; no decode is done in this block.

Reset
REQ-028 When nRST=0 at a rising CLK edge: all outputs 0, FSM IDLE, mem_busy 0; reset beats flush, enable, dhit.
REQ-029 Reset asserted during REQ SHALL drop dREN/dWEN on the next cycle, with no completion.

Verification
REQ-030 LW load: instr_EX=0x8C880004, aluout_EX=0x100, memtoReg_EX=1, enable=1 -> next cycle instr_MEM=0x8C880004, daddr=0x100, dREN=1, mem_busy=1; dhit after 3 cycles -> dREN=0, mem_busy=0 the following cycle.
REQ-031 SW with dhit same cycle as REQ entry -> dWEN high exactly 1 cycle, storedata_MEM=dstore.
REQ-032 Flush during mem_busy -> ignored; after dhit, flush with enable=0 -> all outputs 0.
REQ-033 R-type ADD, RegWr_EX=1, enable=0 for 2 cycles then 1 -> outputs hold old values, then update on one edge; dREN=dWEN=0 throughout.
REQ-034 halt_EX=1 loaded -> halt_MEM=1, stage frozen despite enable=1 and new EX inputs; nRST=0 -> all outputs 0.
REQ-035 nRST=0 mid-REQ -> next cycle dREN=0, mem_busy=0, FSM IDLE.
